register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the register and data-port width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 3, giving the address width, so the file holds 2**ADDR_W registers (R0..R7 by default).
REQ-003 clock  input  1  single clock, rising-edge active; one clock, reset is asynchronous and active-high.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 RW  input  1  register write enable.
REQ-006 DA  input  ADDR_W  destination (write) address.
REQ-007 AA  input  ADDR_W  read address, port A.
REQ-008 BA  input  ADDR_W  read address, port B.
REQ-009 D_data  input  DATA_W  write data, taken from Bus D (function unit result or memory data).
REQ-010 LS  input  1  load-status enable.
REQ-011 V, C, N, Z  input  1 each  status flags from the function unit.
REQ-012 A_data  output  DATA_W  port A read data, driving function unit operand A.
REQ-013 B_data  output  DATA_W  port B read data, driving the Bus B mux.
REQ-014 status  output  4  registered flags {V, C, N, Z}, with V as the MSB.

Function
REQ-015 The block SHALL hold 2**ADDR_W registers of DATA_W bits, all general purpose, with no hard-wired zero register.
REQ-016 On a rising clock edge with RW=1 and reset=0, the block SHALL load R[DA] with D_data; with RW=0, no register SHALL change.
REQ-017 A_data SHALL equal R[AA] and B_data SHALL equal R[BA] combinationally, with zero-cycle read latency.
REQ-018 AA and BA SHALL be allowed to be equal, and both ports SHALL then show the same register.
REQ-019 The write port SHALL accept any DA, including a DA equal to AA and/or BA in the same cycle; read behaviour in that case is set by REQ-026/REQ-027.
REQ-020 A value written at edge k SHALL be visible on A_data/B_data from edge k onward, after propagation.
REQ-021 On a rising edge with LS=1, status SHALL load {V, C, N, Z}; with LS=0, status SHALL hold its value.
REQ-022 RW and LS SHALL be independent, and both may be active in the same cycle.
REQ-023 Any X, Z, or out-of-range write that cannot occur because addresses are fully decoded SHALL NOT need to be handled; every ADDR_W-bit address SHALL be valid.

Reset
REQ-024 While reset=1, all registers and status SHALL be 0 immediately, without waiting for a clock edge; A_data, B_data, and status SHALL read 0.
REQ-025 Reset SHALL take priority over a simultaneous RW or LS, and a write in progress at reset assertion SHALL be discarded.

Configuration
REQ-026 With macro REGFILE_BYPASS_EN defined, A_data SHALL show D_data whenever RW=1 and DA==AA, and B_data SHALL show D_data whenever RW=1 and DA==BA (same-cycle write-through), with reset still forcing 0.
REQ-027 With REGFILE_BYPASS_EN undefined, the read ports SHALL show only stored register contents, so a same-cycle write is visible only after the edge.

Verification
REQ-028 Assert reset mid-cycle with RW=1, DA=3, D_data=16'h1234 -> all registers read 0 and status=4'b0000 at once, without a clock edge, and no write to R3.
REQ-029 Write R0..R7 with 16'h1000+n, then read AA=5, BA=2 -> A_data=16'h1005, B_data=16'h1002; then AA=BA=7 -> both ports show 16'h1007.
REQ-030 Hold RW=0, DA=4, D_data=16'hFFFF for 3 edges -> R4 keeps its previous value 16'h1004.
REQ-031 Before the edge, set RW=1, DA=AA=BA=6, D_data=16'hBEEF with R6=16'h1006 -> with the macro, both ports show 16'hBEEF; without it, both show 16'h1006 until the edge and 16'hBEEF after it.
REQ-032 Clock LS=1 with {V,C,N,Z}=4'b1010, then LS=0 with flags 4'b0101 -> status=4'b1010 after each edge; then LS=1 -> status=4'b0101.
REQ-033 In one cycle, set RW=1, DA=1, D_data=16'h8000, LS=1, flags 4'b0010 -> after the edge, R1=16'h8000 and status=4'b0010.

Source files
------------

// File: rtl/register_file.sv
// Dual-read, single-write general-purpose register file with a registered {V,C,N,Z} status word.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module register_file #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              RW,
    input  logic [ADDR_W-1:0] DA,
    input  logic [ADDR_W-1:0] AA,
    input  logic [ADDR_W-1:0] BA,
    input  logic [DATA_W-1:0] D_data,
    input  logic              LS,
    input  logic              V,
    input  logic              C,
    input  logic              N,
    input  logic              Z,
    output logic [DATA_W-1:0] A_data,
    output logic [DATA_W-1:0] B_data,
    output logic [3:0]        status
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [3:0]        status_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (RW) begin
            regs[DA] <= D_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            status_q <= 4'b0000;
        end else if (LS) begin
            status_q <= {V, C, N, Z};
        end
    end

    // Reset gating keeps the ports at zero even when bypass would forward D_data.
    always_comb begin
        A_data = regs[AA];
        B_data = regs[BA];
`ifdef REGFILE_BYPASS_EN
        if (RW && (DA == AA)) A_data = D_data;
        if (RW && (DA == BA)) B_data = D_data;
`endif
        if (reset) begin
            A_data = '0;
            B_data = '0;
        end
    end

    assign status = status_q;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: vector table plus hand-written reset and write-through sequences.
module tb_register_file;

    logic        clock;
    logic        reset;
    logic        RW;
    logic [2:0]  DA;
    logic [2:0]  AA;
    logic [2:0]  BA;
    logic [15:0] D_data;
    logic        LS;
    logic        V, C, N, Z;
    logic [15:0] A_data;
    logic [15:0] B_data;
    logic [3:0]  status;

    register_file #(.DATA_W(16), .ADDR_W(3)) dut (
        .clock  (clock),
        .reset  (reset),
        .RW     (RW),
        .DA     (DA),
        .AA     (AA),
        .BA     (BA),
        .D_data (D_data),
        .LS     (LS),
        .V      (V),
        .C      (C),
        .N      (N),
        .Z      (Z),
        .A_data (A_data),
        .B_data (B_data),
        .status (status)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  st;
    } exp_t;

    typedef struct {
        string       name;
        logic        rw;
        logic [2:0]  da;
        logic [2:0]  aa;
        logic [2:0]  ba;
        logic [15:0] d;
        logic        ls;
        logic [3:0]  flags;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        logic [3:0]  exp_st;
    } vec_t;

    exp_t sb[$];
    vec_t vecs [12];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic expect_out(input string nm, input logic [15:0] a,
                              input logic [15:0] b, input logic [3:0] st);
        exp_t e;
        e.name = nm; e.a = a; e.b = b; e.st = st;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL scoreboard_empty: actual no entry, required one entry");
            return;
        end
        e = sb.pop_front();
        n_cmp++;
        if (A_data !== e.a) begin
            n_err++;
            $display("FAIL %s A_data: actual %h required %h", e.name, A_data, e.a);
        end
        n_cmp++;
        if (B_data !== e.b) begin
            n_err++;
            $display("FAIL %s B_data: actual %h required %h", e.name, B_data, e.b);
        end
        n_cmp++;
        if (status !== e.st) begin
            n_err++;
            $display("FAIL %s status: actual %b required %b", e.name, status, e.st);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic vec_t mk(input string nm, input logic rw, input logic [2:0] da,
                                input logic [2:0] aa, input logic [2:0] ba,
                                input logic [15:0] d, input logic ls, input logic [3:0] fl,
                                input logic [15:0] ea, input logic [15:0] eb,
                                input logic [3:0] es);
        vec_t v;
        v.name = nm; v.rw = rw; v.da = da; v.aa = aa; v.ba = ba; v.d = d;
        v.ls = ls; v.flags = fl; v.exp_a = ea; v.exp_b = eb; v.exp_st = es;
        return v;
    endfunction

    initial begin
        // Expected values assume R_n = 16'h1000+n and status = 0 before vector 0.
        vecs[0]  = mk("read_5_2",    0, 0, 5, 2, 16'h0000, 0, 4'b0000, 16'h1005, 16'h1002, 4'b0000);
        vecs[1]  = mk("read_7_7",    0, 0, 7, 7, 16'h0000, 0, 4'b0000, 16'h1007, 16'h1007, 4'b0000);
        vecs[2]  = mk("read_0_1",    0, 0, 0, 1, 16'h0000, 0, 4'b0000, 16'h1000, 16'h1001, 4'b0000);
        vecs[3]  = mk("ls_1010",     0, 0, 3, 4, 16'h0000, 1, 4'b1010, 16'h1003, 16'h1004, 4'b1010);
        vecs[4]  = mk("hold_a",      0, 0, 3, 4, 16'h0000, 0, 4'b0101, 16'h1003, 16'h1004, 4'b1010);
        vecs[5]  = mk("hold_b",      0, 0, 6, 5, 16'h0000, 0, 4'b0101, 16'h1006, 16'h1005, 4'b1010);
        vecs[6]  = mk("ls_0101",     0, 0, 6, 5, 16'h0000, 1, 4'b0101, 16'h1006, 16'h1005, 4'b0101);
        vecs[7]  = mk("rw_ls_same",  1, 1, 1, 0, 16'h8000, 1, 4'b0010, 16'h8000, 16'h1000, 4'b0010);
        vecs[8]  = mk("rw0_r4_1",    0, 4, 4, 4, 16'hFFFF, 0, 4'b1111, 16'h1004, 16'h1004, 4'b0010);
        vecs[9]  = mk("rw0_r4_2",    0, 4, 4, 4, 16'hFFFF, 0, 4'b1111, 16'h1004, 16'h1004, 4'b0010);
        vecs[10] = mk("rw0_r4_3",    0, 4, 4, 4, 16'hFFFF, 0, 4'b1111, 16'h1004, 16'h1004, 4'b0010);
        vecs[11] = mk("wr_r0",       1, 0, 0, 7, 16'hA5A5, 0, 4'b0000, 16'hA5A5, 16'h1007, 4'b0010);

        RW = 0; DA = 0; AA = 0; BA = 0; D_data = 0; LS = 0;
        {V, C, N, Z} = 4'b0000;
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            AA = 3'(i); BA = 3'(7 - i);
            expect_out($sformatf("reset_init_%0d", i), 16'h0000, 16'h0000, 4'b0000);
            #1 check_out();
        end
        step();
        step();
        reset = 1'b0;

        for (int n = 0; n < 8; n++) begin
            RW = 1; DA = 3'(n); D_data = 16'h1000 + 16'(n);
            step();
        end
        RW = 0;

        for (int i = 0; i < 12; i++) begin
            RW = vecs[i].rw; DA = vecs[i].da; AA = vecs[i].aa; BA = vecs[i].ba;
            D_data = vecs[i].d; LS = vecs[i].ls; {V, C, N, Z} = vecs[i].flags;
            expect_out(vecs[i].name, vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_st);
            step();
            check_out();
        end
        RW = 0; LS = 0;

        // Same-cycle write to a register being read on both ports.
        RW = 1; DA = 6; AA = 6; BA = 6; D_data = 16'hBEEF;
`ifdef REGFILE_BYPASS_EN
        expect_out("wt_pre_edge", 16'hBEEF, 16'hBEEF, 4'b0010);
`else
        expect_out("wt_pre_edge", 16'h1006, 16'h1006, 4'b0010);
`endif
        #1 check_out();
        expect_out("wt_post_edge", 16'hBEEF, 16'hBEEF, 4'b0010);
        step();
        RW = 0;
        #1 check_out();

        // Reset asserted mid-cycle while a write to R3 is pending.
        LS = 1; {V, C, N, Z} = 4'b1111;
        step();
        LS = 0;
        RW = 1; DA = 3; D_data = 16'h1234;
        #2 reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            AA = 3'(i); BA = 3'(7 - i);
            expect_out($sformatf("async_rst_%0d", i), 16'h0000, 16'h0000, 4'b0000);
            #1 check_out();
        end
        step();
        RW = 0;
        #1 reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            AA = 3'(i); BA = 3'd3;
            expect_out($sformatf("post_rst_%0d", i), 16'h0000, 16'h0000, 4'b0000);
            #1 check_out();
        end

        if (sb.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL scoreboard_leftover: actual %0d entries, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
